// File: rtl/rbm_axi_pkg.sv
// Shared definitions for the register-bus to AXI4-Lite master:
// FSM state encoding and AXI response codes.
package rbm_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_RSP   = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rbm_axil_master.sv
// Single-outstanding AXI4-Lite master: turns one host command into an AXI
// write or read and returns the captured response, with a sticky phase timeout.
module rbm_axil_master
    import rbm_axi_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    output logic [ADDR_W-1:0] M_AWADDR,
    output logic              M_AWVALID,
    input  logic              M_AWREADY,
    output logic [31:0]       M_WDATA,
    output logic [3:0]        M_WSTRB,
    output logic              M_WVALID,
    input  logic              M_WREADY,
    input  logic [1:0]        M_BRESP,
    input  logic              M_BVALID,
    output logic              M_BREADY,
    output logic [ADDR_W-1:0] M_ARADDR,
    output logic              M_ARVALID,
    input  logic              M_ARREADY,
    input  logic [31:0]       M_RDATA,
    input  logic [1:0]        M_RRESP,
    input  logic              M_RVALID,
    output logic              M_RREADY,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              timeout
);

    localparam int             CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_wstrb;
    logic               r_awvalid;
    logic               r_wvalid;
    logic               r_bready;
    logic               r_arvalid;
    logic               r_rready;
    logic               r_cmd_ready;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_rdata;
    logic [1:0]         r_rsp_resp;
    logic               r_timeout;

    logic               w_aw_fin;
    logic               w_w_fin;
    logic               w_in_phase;

    // A channel counts as finished once its valid has dropped or is handshaking now
    assign w_aw_fin   = ~r_awvalid | M_AWREADY;
    assign w_w_fin    = ~r_wvalid  | M_WREADY;
    assign w_in_phase = (r_state == ST_WRITE) || (r_state == ST_WRESP) ||
                        (r_state == ST_RADDR) || (r_state == ST_RDATA);

    // Transaction FSM with registered AXI and host-side outputs
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= 32'h0000_0000;
            r_wstrb     <= 4'h0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
            r_rsp_resp  <= RESP_OKAY;
            r_timeout   <= 1'b0;
        end else begin
            if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Flag only; the transaction keeps waiting for the slave
            if (w_in_phase && (r_cnt == CNT_MAX)) begin
                r_timeout <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_cnt       <= '0;
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wdata;
                        r_wstrb     <= cmd_wstrb;
                        if (cmd_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_WRITE;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RADDR;
                        end
                    end
                end
                ST_WRITE: begin
                    if (M_AWREADY) r_awvalid <= 1'b0;
                    if (M_WREADY)  r_wvalid  <= 1'b0;
                    if (w_aw_fin && w_w_fin) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b0;
                        r_bready  <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (M_BVALID) begin
                        r_bready    <= 1'b0;
                        r_rsp_resp  <= M_BRESP;
                        r_rsp_rdata <= 32'h0000_0000;
                        r_rsp_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RADDR: begin
                    if (M_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (M_RVALID) begin
                        r_rready    <= 1'b0;
                        r_rsp_resp  <= M_RRESP;
                        r_rsp_rdata <= M_RDATA;
                        r_rsp_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_awvalid   <= 1'b0;
                    r_wvalid    <= 1'b0;
                    r_bready    <= 1'b0;
                    r_arvalid   <= 1'b0;
                    r_rready    <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign M_AWADDR  = r_addr;
    assign M_ARADDR  = r_addr;
    assign M_AWVALID = r_awvalid;
    assign M_WDATA   = r_wdata;
    assign M_WSTRB   = r_wstrb;
    assign M_WVALID  = r_wvalid;
    assign M_BREADY  = r_bready;
    assign M_ARVALID = r_arvalid;
    assign M_RREADY  = r_rready;
    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;
    assign timeout   = r_timeout;

endmodule

// File: doc/rbm_axil_master.md
RBM_AXIL_MASTER -- requirements
Module: rbm_axil_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, cycles before timeout flag.
REQ-003 SHALL have ACLK  in  1  sole clock.
REQ-004 SHALL have ARESETn  in  1  asynchronous active-low reset.
REQ-005 SHALL have M_AWADDR  out  ADDR_W  write address.
REQ-006 SHALL have M_AWVALID  out  1  write address valid.
REQ-007 SHALL have M_AWREADY  in  1  write address ready.
REQ-008 SHALL have M_WDATA  out  32  write data.
REQ-009 SHALL have M_WSTRB  out  4  byte strobes.
REQ-010 SHALL have M_WVALID  out  1  write data valid.
REQ-011 SHALL have M_WREADY  in  1  write data ready.
REQ-012 SHALL have M_BRESP  in  2  write response.
REQ-013 SHALL have M_BVALID  in  1  write response valid.
REQ-014 SHALL have M_BREADY  out  1  write response ready.
REQ-015 SHALL have M_ARADDR  out  ADDR_W  read address.
REQ-016 SHALL have M_ARVALID  out  1  read address valid.
REQ-017 SHALL have M_ARREADY  in  1  read address ready.
REQ-018 SHALL have M_RDATA  in  32  read data.
REQ-019 SHALL have M_RRESP  in  2  read response.
REQ-020 SHALL have M_RVALID  in  1  read data valid.
REQ-021 SHALL have M_RREADY  out  1  read data ready.
REQ-022 SHALL have cmd_valid  in  1  command request.
REQ-023 SHALL have cmd_ready  out  1  command accepted.
REQ-024 SHALL have cmd_write  in  1  1 write, 0 read.
REQ-025 SHALL have cmd_addr  in  ADDR_W  target address.
REQ-026 SHALL have cmd_wdata  in  32  write data.
REQ-027 SHALL have cmd_wstrb  in  4  write strobes.
REQ-028 SHALL have rsp_valid  out  1  response available.
REQ-029 SHALL have rsp_ready  in  1  response consumed.
REQ-030 SHALL have rsp_rdata  out  32  read data (0 for writes).
REQ-031 SHALL have rsp_resp  out  2  BRESP/RRESP captured.
REQ-032 SHALL have timeout  out  1  sticky: a phase exceeded TIMEOUT_CYC.

Function
REQ-033 SHALL implement FSM IDLE, WRITE (AW+W), WRESP, RADDR, RDATA, RSP; one transaction outstanding.
REQ-034 cmd_ready SHALL be 1 only in IDLE; a cmd_valid&cmd_ready cycle registers addr/data/strb and moves to WRITE or RADDR next cycle.
REQ-035 WRITE: AWVALID and WVALID SHALL assert together; each deasserts the cycle after its own handshake; go to WRESP once both done (same-cycle or either order).
REQ-036 WRESP: BREADY=1; on BVALID capture BRESP, rdata=0, go RSP. RADDR: ARVALID until ARREADY, then RDATA. RDATA: RREADY=1; on RVALID capture RDATA/RRESP, go RSP.
REQ-037 Valid outputs SHALL not drop and address/data SHALL not change before handshake; no combinational path from any AXI ready to any valid.
REQ-038 RSP: rsp_valid=1 with stable data until rsp_ready, then IDLE; minimum command-to-rsp_valid latency 3 cycles with all slave inputs held high.
REQ-039 A per-phase counter SHALL reset on each state entry; reaching TIMEOUT_CYC sets timeout, transaction keeps waiting (never abandons); timeout clears on next cmd acceptance.
REQ-040 SLVERR/DECERR responses SHALL pass unchanged on rsp_resp; no retry.

Reset
REQ-041 ARESETn low SHALL force IDLE and all outputs 0 (cmd_ready goes 1 only after reset release) regardless of in-flight transaction.

Structure
REQ-042 FSM state enum and AXI resp codes (OKAY, EXOKAY, SLVERR, DECERR) SHALL live in shared package rbm_axi_pkg; single module, no sub-modules.

Verification
REQ-043 Write 0xDEADBEEF to 0x08, strobe 0xF, slave always ready -> one AW/W beat, rsp_resp=0, rsp_valid at cycle 3.
REQ-044 Write with AWREADY 4 cycles before WREADY -> AWVALID drops after AW handshake, WVALID held until WREADY, single B accepted.
REQ-045 Read 0x04 returning 0x00000005 with RVALID after 5 cycles -> rsp_rdata=0x5, rsp_resp=0.
REQ-046 Read with RRESP=2 and rsp_ready held low 3 cycles -> rsp_resp=2, rsp_valid and data stable, cmd_ready low until consumed.
REQ-047 TIMEOUT_CYC=8, BVALID withheld 20 cycles -> timeout set at cycle 8 of WRESP, completes normally, cleared by next command.
REQ-048 ARESETn asserted during RDATA -> all outputs 0 immediately; after release new read completes correctly.
